maxpool2x2_engine: RTL
======================

MAXPOOL2X2_ENGINE -- requirements
Module: maxpool2x2_engine

Interface
REQ-001 Parameter: DATA_W, default 8, signed element width in bits.
REQ-002 Parameter: IN_DIM, default 6, input feature-map side length; SHALL be even and at least 2; output side is OUT_DIM = IN_DIM/2.
REQ-003 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: enable  input  1  start request, sampled on clk; a one-cycle pulse from the layer sequencer.
REQ-006 Port: input_fm  input  IN_DIM*IN_DIM*DATA_W  signed feature map, element i at bits [DATA_W*i +: DATA_W], i = row*IN_DIM + col.
REQ-007 Port: output_fm  output  OUT_DIM*OUT_DIM*DATA_W  pooled map, same packing with OUT_DIM.
REQ-008 Port: done  output  1  result valid, held high until the next accepted start.
REQ-009 Port: busy  output  1  high while a scan is in progress.

Function
REQ-010 FSM states SHALL be IDLE, SCAN and DONE; only reset enters IDLE.
REQ-011 IDLE or DONE with enable=1 SHALL snapshot input_fm into an internal register, clear done, set busy, clear the counters and go to SCAN on the same edge.
REQ-012 Enable while in SCAN SHALL be ignored with no effect on the scan in progress.
REQ-013 SCAN SHALL process one element per cycle, taken from the snapshot only; input_fm may change freely after the start edge.
REQ-014 Windows SHALL be visited row-major, (r,c) for r,c = 0..OUT_DIM-1.
REQ-015 Elements within a window SHALL be visited in the order (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
REQ-016 The first element of a window SHALL load the running max; each later element SHALL replace it if strictly greater under signed compare.
REQ-017 After the 4th element the window max SHALL be written to output_fm element r*OUT_DIM+c; other output elements SHALL be unchanged.
REQ-018 When the last element of window OUT_DIM*OUT_DIM-1 is processed, the FSM SHALL enter DONE, set done=1 and clear busy.
REQ-019 Latency: start edge at cycle N gives done=1 after edge N + 4*OUT_DIM*OUT_DIM + 1, which is N+37 for the defaults.
REQ-020 output_fm SHALL hold its final values while in DONE and until overwritten during the next scan.
REQ-021 The element counter (0..3) and window counter (0..OUT_DIM^2-1) SHALL wrap to 0 on entering DONE.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE, done=0, busy=0, output_fm=0, counters=0, running max=0 and snapshot=0, including mid-scan.
REQ-023 After rst_n deasserts, the first start SHALL be accepted only on an enable sampled at a clk edge where rst_n=1.

Configuration
REQ-024 With macro POOL_RELU_EN defined, each window max SHALL be clamped to 0 if negative before it is written to output_fm.
REQ-025 Without POOL_RELU_EN, window maxima SHALL be written unmodified, negative values included.

Structure
REQ-026 Shared package cnn_pkg SHALL hold DATA_W, the feature-map dimension constants and the pool FSM state enum.
REQ-027 One sub-module pool_max_cmp SHALL implement the signed compare-and-select and the optional ReLU clamp.

Verification
REQ-028 Test: all 36 inputs = index i (0..35), then enable pulse. Required: done rises at cycle N+37 and output_fm = {7,9,11,19,21,23,31,33,35}.
REQ-029 Test: all inputs = -5. Required without POOL_RELU_EN: every output = -5; required with it: every output = 0.
REQ-030 Test: window 0 = {-128,127,0,-1}, all other inputs 0. Required: output[0] = 127; first-element load of -128 does not leak.
REQ-031 Test: second enable at SCAN cycle 10, and input_fm changed to all 0x55 after the start edge. Required: done still at N+37 and results are from the snapshot only.
REQ-032 Test: rst_n pulsed low at SCAN cycle 20. Required: outputs 0 and busy=0 immediately; a fresh start completes with correct results.
REQ-033 Test: enable while in DONE. Required: done drops on that edge and a new scan completes 37 cycles later.

Source files
------------

// File: rtl/cnn_pkg.sv
// ============================================================================
// cnn_pkg : shared CNN datapath constants, pool FSM state type, index helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package cnn_pkg;

  localparam int DATA_W  = 8;
  localparam int IN_DIM  = 6;
  localparam int OUT_DIM = IN_DIM / 2;
  localparam int WIN_CNT = OUT_DIM * OUT_DIM;

  typedef enum logic [1:0] {
    POOL_IDLE = 2'd0,
    POOL_SCAN = 2'd1,
    POOL_DONE = 2'd2
  } pool_state_e;

  // Flat input index of sub-element 'sub' (0..3, row-major) of window 'win'.
  function automatic int unsigned pool_index(input int unsigned win,
                                             input int unsigned sub,
                                             input int unsigned in_dim);
    int unsigned od;
    od = in_dim / 2;
    return (2 * (win / od) + sub / 2) * in_dim + 2 * (win % od) + sub % 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pool_max_cmp.sv
// ============================================================================
// pool_max_cmp : signed compare-and-select for the running window max, plus
// the write-back value (clamped at zero when POOL_RELU_EN is defined).
// Revision: 1.0
// ============================================================================
`default_nettype none

module pool_max_cmp #(
  parameter int DATA_W = cnn_pkg::DATA_W
) (
  input  logic signed [DATA_W-1:0] cur_max,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     first,
  output logic signed [DATA_W-1:0] max_out,
  output logic signed [DATA_W-1:0] wr_val
);

  always_comb begin
    max_out = cur_max;
    if (first || (din > cur_max)) begin
      max_out = din;
    end
`ifdef POOL_RELU_EN
    wr_val = max_out[DATA_W-1] ? '0 : max_out;
`else
    wr_val = max_out;
`endif
  end

endmodule

`default_nettype wire

// File: rtl/maxpool2x2_engine.sv
// ============================================================================
// maxpool2x2_engine : sequential 2x2/stride-2 max pooling, one element per
// cycle from an input snapshot. Optional ReLU clamp via POOL_RELU_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module maxpool2x2_engine #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int IN_DIM = cnn_pkg::IN_DIM
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        enable,
  input  logic [IN_DIM*IN_DIM*DATA_W-1:0]             input_fm,
  output logic [(IN_DIM/2)*(IN_DIM/2)*DATA_W-1:0]     output_fm,
  output logic                                        done,
  output logic                                        busy
);

  import cnn_pkg::*;

  localparam int OUT_D = IN_DIM / 2;
  localparam int N_WIN = OUT_D * OUT_D;
  localparam int WIN_W = (N_WIN > 1) ? $clog2(N_WIN) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(N_WIN - 1);

  pool_state_e                       state_q, state_d;
  logic [IN_DIM*IN_DIM*DATA_W-1:0]   snap_q, snap_d;
  logic [N_WIN*DATA_W-1:0]           out_q, out_d;
  logic [1:0]                        elem_q, elem_d;
  logic [WIN_W-1:0]                  win_q, win_d;
  logic signed [DATA_W-1:0]          pix_q, pix_d;
  logic signed [DATA_W-1:0]          max_q, max_d;
  logic                              pvalid_q, pvalid_d;
  logic [1:0]                        pelem_q, pelem_d;
  logic [WIN_W-1:0]                  pwin_q, pwin_d;
  logic                              done_q, done_d;
  logic                              busy_q, busy_d;

  int unsigned                       fetch_idx;
  logic signed [DATA_W-1:0]          cmp_max;
  logic signed [DATA_W-1:0]          cmp_wr;

  pool_max_cmp #(.DATA_W(DATA_W)) u_cmp (
    .cur_max (max_q),
    .din     (pix_q),
    .first   (pelem_q == 2'd0),
    .max_out (cmp_max),
    .wr_val  (cmp_wr)
  );

  // Two-stage scan: fetch element from the snapshot, then fold it into the max.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    out_d     = out_q;
    elem_d    = elem_q;
    win_d     = win_q;
    pix_d     = pix_q;
    max_d     = max_q;
    pvalid_d  = pvalid_q;
    pelem_d   = pelem_q;
    pwin_d    = pwin_q;
    done_d    = done_q;
    busy_d    = busy_q;
    fetch_idx = pool_index(32'(win_q), 32'(elem_q), IN_DIM);

    case (state_q)
      POOL_IDLE, POOL_DONE: begin
        if (enable) begin
          snap_d   = input_fm;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          elem_d   = 2'd0;
          win_d    = '0;
          pvalid_d = 1'b0;
          state_d  = POOL_SCAN;
        end
      end
      POOL_SCAN: begin
        // Counters back at zero with a valid stage means every element is fetched.
        if (!(pvalid_q && (win_q == '0) && (elem_q == 2'd0))) begin
          pix_d    = snap_q[DATA_W*fetch_idx +: DATA_W];
          pvalid_d = 1'b1;
          pelem_d  = elem_q;
          pwin_d   = win_q;
          elem_d   = elem_q + 2'd1;
          if (elem_q == 2'd3) begin
            win_d = (win_q == WIN_LAST) ? '0 : win_q + WIN_W'(1);
          end
        end
        if (pvalid_q) begin
          max_d = cmp_max;
          if (pelem_q == 2'd3) begin
            out_d[DATA_W*int'(pwin_q) +: DATA_W] = cmp_wr;
            if (pwin_q == WIN_LAST) begin
              state_d = POOL_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = POOL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= POOL_IDLE;
      snap_q   <= '0;
      out_q    <= '0;
      elem_q   <= 2'd0;
      win_q    <= '0;
      pix_q    <= '0;
      max_q    <= '0;
      pvalid_q <= 1'b0;
      pelem_q  <= 2'd0;
      pwin_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      out_q    <= out_d;
      elem_q   <= elem_d;
      win_q    <= win_d;
      pix_q    <= pix_d;
      max_q    <= max_d;
      pvalid_q <= pvalid_d;
      pelem_q  <= pelem_d;
      pwin_q   <= pwin_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign output_fm = out_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire
